// File: rtl/sync_filter_multi.sv
// Multi-channel input synchronizer with an optional consecutive-sample glitch
// filter and registered rise/fall pulses, all in the CLK domain.
module sync_filter_multi #(
  parameter int                NUM_CH     = 4,
  parameter int                NUM_STAGES = 2,
  parameter logic [NUM_CH-1:0] RST_VAL    = {NUM_CH{1'b0}},
  parameter int                FILTER_LEN = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              flt_en,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  localparam bit FILT_AVAIL = (FILTER_LEN >= 2);
  localparam int CNT_W      = FILT_AVAIL ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_AVAIL ? FILTER_LEN - 1 : 0);

  logic              filt_on;
  logic [NUM_CH-1:0] dout_reg;
  logic [NUM_CH-1:0] dout_next;
  logic [NUM_CH-1:0] rise_reg;
  logic [NUM_CH-1:0] fall_reg;

  // A filter length below 2 degenerates to plain bypass regardless of flt_en.
  assign filt_on = flt_en & FILT_AVAIL;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [NUM_STAGES-1:0] stg_reg;
      logic [CNT_W-1:0]      cnt_reg;
      logic [CNT_W-1:0]      cnt_next;
      logic                  sync_bit;
      logic                  dout_nx;

      always_ff @(posedge CLK) begin
        if (rst) begin
          stg_reg <= {NUM_STAGES{RST_VAL[gi]}};
          cnt_reg <= '0;
        end else begin
          stg_reg <= {stg_reg[NUM_STAGES-2:0], din[gi]};
          cnt_reg <= cnt_next;
        end
      end

      assign sync_bit = stg_reg[NUM_STAGES-1];

      // dout only flips on the FILTER_LEN-th consecutive differing sample.
      always_comb begin
        dout_nx  = dout_reg[gi];
        cnt_next = '0;
        if (!filt_on) begin
          dout_nx = sync_bit;
        end else if (sync_bit != dout_reg[gi]) begin
          if (cnt_reg == CNT_MAX) begin
            dout_nx = sync_bit;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      assign dout_next[gi] = dout_nx;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (rst) begin
      dout_reg <= RST_VAL;
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      dout_reg <= dout_next;
      rise_reg <= dout_next & ~dout_reg;
      fall_reg <= ~dout_next & dout_reg;
    end
  end

  assign dout = dout_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: tb/tb_sync_filter_multi.sv
// Directed bench for sync_filter_multi: a history-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_sync_filter_multi;

  localparam int         NCH  = 4;
  localparam int         NST  = 2;
  localparam int         FLEN = 4;
  localparam logic [3:0] RV   = 4'b0101;
  localparam int         MAXE = 2048;

  logic       CLK = 1'b0;
  logic       rst;
  logic       flt_en;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;

  int pass_cnt = 0;
  int total    = 0;

  sync_filter_multi #(
    .NUM_CH    (NCH),
    .NUM_STAGES(NST),
    .RST_VAL   (RV),
    .FILTER_LEN(FLEN)
  ) dut (
    .CLK   (CLK),
    .rst   (rst),
    .flt_en(flt_en),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 CLK = ~CLK;

  // Per-edge record of sampled inputs; the model derives outputs from it.
  logic [3:0] h_din [0:MAXE-1];
  bit         h_en  [0:MAXE-1];
  bit         h_rst [0:MAXE-1];
  int         ecnt    = 0;
  bit         m_valid = 0;
  logic [3:0] m_dout;
  logic [3:0] m_rise;
  logic [3:0] m_fall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Synchronized level seen at edge e: din from NST edges earlier, unless a
  // reset edge in between refilled the chain.
  function automatic logic [3:0] sync_at(input int e);
    if (e - NST < 0) return RV;
    for (int j = e - NST; j < e; j++) if (h_rst[j]) return RV;
    return h_din[e - NST];
  endfunction

  // True when the last FLEN edges were all filtered, post-reset, and all
  // presented a level different from cur.
  function automatic bit window_full(input int e, input int c, input logic cur);
    logic [3:0] s;
    if (e - FLEN + 1 < 0) return 1'b0;
    for (int j = e - FLEN + 1; j <= e; j++) begin
      if (h_rst[j] || !h_en[j]) return 1'b0;
      s = sync_at(j);
      if (s[c] == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin : model
    logic [3:0] nd;
    forever begin
      @(posedge CLK);
      h_din[ecnt] = din;
      h_en[ecnt]  = flt_en;
      h_rst[ecnt] = rst;
      if (rst) begin
        m_dout = RV;
        m_rise = '0;
        m_fall = '0;
      end else begin
        nd = m_dout;
        if (!flt_en) nd = sync_at(ecnt);
        else for (int c = 0; c < NCH; c++)
          if (window_full(ecnt, c, m_dout[c])) nd[c] = ~m_dout[c];
        m_rise = nd & ~m_dout;
        m_fall = ~nd & m_dout;
        m_dout = nd;
      end
      m_valid = 1'b1;
      if (ecnt < MAXE - 1) ecnt++;
    end
  end

  initial begin : compare
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        chk("cyc_dout", dout, m_dout);
        chk("cyc_rise", rise, m_rise);
        chk("cyc_fall", fall, m_fall);
      end
    end
  end

  initial begin : driver
    int         first;
    int         nh, nr, nf;
    logic [3:0] acc;
    logic [3:0] rv, fv;

    rst = 1'b1; flt_en = 1'b1; din = 4'b1111;
    repeat (3) @(negedge CLK);
    chk("rst_dout", dout, 4'b0101);
    chk("rst_rise", rise, 4'b0000);
    chk("rst_fall", fall, 4'b0000);
    chk("mdl_rst_dout", m_dout, 4'b0101);

    // Release with din=1111: channels 1 and 3 arrive on the 6th edge.
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      if (k == 5) chk("rel_pre_dout", dout, 4'b0101);
      if (k == 6) begin
        chk("rel_dout", dout, 4'b1111);
        chk("rel_rise", rise, 4'b1010);
        chk("rel_fall", fall, 4'b0000);
        chk("mdl_rel_rise", m_rise, 4'b1010);
      end
      if (k == 7) chk("rel_rise_end", rise, 4'b0000);
    end
    $display("txn release: dout=%b", dout);

    // Three-cycle glitch on ch0 must vanish.
    din = 4'b0000;
    repeat (10) @(negedge CLK);
    chk("glitch_base", dout, 4'b0000);
    din = 4'b0001; acc = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (k == 3) din = 4'b0000;
      acc[0] = acc[0] | dout[0] | rise[0] | fall[0];
    end
    chk("glitch_reject", acc, 4'b0000);
    $display("txn glitch: acc=%b", acc);

    // Four-cycle pulse passes through, delayed by 6 edges.
    din = 4'b0001; first = -1; nh = 0; nr = 0; nf = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (dout[0]) nh++;
      if (dout[0] && first < 0) first = k;
      nr += int'(rise[0]);
      nf += int'(fall[0]);
      if (k == 4) din = 4'b0000;
    end
    chk("pulse_lat", first, 6);
    chk("pulse_width", nh, 4);
    chk("pulse_nrise", nr, 1);
    chk("pulse_nfall", nf, 1);
    $display("txn pulse: lat=%0d width=%0d", first, nh);

    // Bypass: only the synchronizer latency remains.
    flt_en = 1'b0;
    repeat (3) @(negedge CLK);
    din = 4'b0100; first = -1; rv = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (dout[2] && first < 0) begin first = k; rv = rise; end
    end
    chk("byp_lat", first, 3);
    chk("byp_rise", rv, 4'b0100);
    $display("txn bypass: lat=%0d", first);

    // Reset while ch1 counter sits at 2.
    din = 4'b0000;
    repeat (3) @(negedge CLK);
    flt_en = 1'b1;
    repeat (3) @(negedge CLK);
    din = 4'b1111;
    repeat (4) @(negedge CLK);
    chk("mid_pre_dout", dout, 4'b0000);
    rst = 1'b1;
    @(negedge CLK);
    chk("mid_rst_dout", dout, 4'b0101);
    chk("mid_rst_rise", rise, 4'b0000);
    chk("mid_rst_fall", fall, 4'b0000);
    rst = 1'b0; first = -1; rv = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (dout == 4'b1111 && first < 0) begin first = k; rv = rise; end
    end
    chk("mid_lat", first, 6);
    chk("mid_rise", rv, 4'b1010);
    $display("txn midrst: lat=%0d", first);

    // Drop the filter while ch3 is mid-count: bypass takes over next edge.
    repeat (2) @(negedge CLK);
    din = 4'b0111;
    repeat (4) @(negedge CLK);
    chk("sw_hold", dout, 4'b1111);
    flt_en = 1'b0;
    @(negedge CLK);
    chk("sw_dout", dout, 4'b0111);
    chk("sw_fall", fall, 4'b1000);
    $display("txn switch: dout=%b", dout);

    // Opposite steps on ch0 and ch2 in the same cycle.
    flt_en = 1'b1; din = 4'b0011;
    repeat (10) @(negedge CLK);
    chk("ind_base", dout, 4'b0011);
    din = 4'b0110; first = -1; rv = '0; fv = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      if (dout == 4'b0110 && first < 0) begin first = k; rv = rise; fv = fall; end
    end
    chk("ind_lat", first, 6);
    chk("ind_rise", rv, 4'b0100);
    chk("ind_fall", fv, 4'b0001);
    $display("txn indep: rise=%b fall=%b", rv, fv);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
